// File: rtl/crc_rx_check_if.sv
// crc_rx_check_if: serial bit input, generator select and result/counter outputs of the CRC receive checker
interface crc_rx_check_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 3,
    parameter int CNT_W  = 8
);
    logic [0:CRC_W]        divisor;
    logic                  bit_in;
    logic                  bit_valid;
    logic                  bit_ready;
    logic                  frame_abort;
    logic                  out_valid;
    logic                  out_ready;
    logic [0:DATA_W-1]     out_data;
    logic [0:CRC_W-1]      out_rem;
    logic                  crc_err;
    logic [CNT_W-1:0]      frame_cnt;
    logic [CNT_W-1:0]      err_cnt;
    modport master (
        output divisor, bit_in, bit_valid, frame_abort, out_ready,
        input  bit_ready, out_valid, out_data, out_rem, crc_err, frame_cnt, err_cnt
    );
    modport slave (
        input  divisor, bit_in, bit_valid, frame_abort, out_ready,
        output bit_ready, out_valid, out_data, out_rem, crc_err, frame_cnt, err_cnt
    );
endinterface

// File: rtl/crc_rx_check.sv
// crc_rx_check: bit-serial CRC codeword checker with held result and saturating frame/error counters
module crc_rx_check #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 3,
    parameter int CNT_W  = 8
) (
    input logic           clk,
    input logic           rst,
    crc_rx_check_if.slave bus
);
    localparam int N  = DATA_W + CRC_W;
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;
    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [0:CRC_W-1]  rem, r, r_nx;
    logic [0:CRC_W]    gen, g;
    logic [0:DATA_W-1] sr;
    logic              acc, last;
    assign bus.bit_ready = state != HOLD;
    assign bus.out_valid = state == HOLD;
    // first bit of a frame divides from a zero remainder with the live divisor
    always_comb begin
        acc      = bus.bit_valid && bus.bit_ready;
        last     = cnt == CW'(N - 1);
        g        = state == IDLE ? bus.divisor : gen;
        r        = state == IDLE ? '0 : rem;
        r_nx     = {r[1:CRC_W-1], bus.bit_in} ^ (r[0] ? g[1:CRC_W] : '0);
        state_nx = state == HOLD ? (bus.out_ready ? IDLE : HOLD)
                 : bus.frame_abort ? IDLE
                 : acc ? (last ? HOLD : RECV) : state;
    end
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    // datapath: LFSR, data shift, result latch on the last bit, counters on delivery
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            rem           <= '0;
            gen           <= '0;
            sr            <= '0;
            bus.out_data  <= '0;
            bus.out_rem   <= '0;
            bus.crc_err   <= 1'b0;
            bus.frame_cnt <= '0;
            bus.err_cnt   <= '0;
        end else if (state == HOLD) begin
            if (bus.out_ready) begin
                cnt <= '0;
                rem <= '0;
                if (~&bus.frame_cnt) bus.frame_cnt <= bus.frame_cnt + CNT_W'(1);
                if (bus.crc_err && ~&bus.err_cnt) bus.err_cnt <= bus.err_cnt + CNT_W'(1);
            end
        end else if (bus.frame_abort) begin
            cnt <= '0;
            rem <= '0;
        end else if (acc) begin
            cnt <= cnt + CW'(1);
            rem <= r_nx;
            if (state == IDLE) gen <= bus.divisor;
            if (cnt < CW'(DATA_W)) sr <= {sr[1:DATA_W-1], bus.bit_in};
            if (last) begin
                bus.out_data <= sr;
                bus.out_rem  <= r_nx;
                bus.crc_err  <= (|r_nx) | ~g[0];
            end
        end
    end
endmodule

// File: tb/tb_crc_rx_check.sv
// tb_crc_rx_check: table, hand-written and randomized checks of crc_rx_check against a polynomial-division model
module tb_crc_rx_check;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int fc = 0;
    int ec = 0;
    typedef struct {
        logic [3:0]  dv;
        logic [10:0] cw;
        logic [7:0]  d;
        logic [2:0]  r;
        logic        e;
    } vec_t;
    vec_t tbl[6];
    always #5 clk = ~clk;
    crc_rx_check_if bus();
    crc_rx_check dut (.clk(clk), .rst(rst), .bus(bus));
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    function automatic logic [2:0] model_rem(input logic [10:0] cw, input logic [3:0] dv);
        logic [10:0] v;
        v = cw;
        for (int i = 10; i >= 3; i--)
            if (v[i]) v = v ^ ({7'd0, 1'b1, dv[2:0]} << (i - 3));
        return v[2:0];
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic send(input logic [10:0] cw, input int n, input bit gaps, input logic [3:0] dv_late);
        for (int i = 0; i < n; i++) begin
            if (gaps)
                while ($urandom_range(0, 3) == 0) begin
                    bus.bit_valid = 1'b0;
                    bus.bit_in = 1'($urandom);
                    tick();
                end
            bus.bit_valid = 1'b1;
            bus.bit_in = cw[10-i];
            tick();
            if (i == 0) bus.divisor = dv_late;
        end
        bus.bit_valid = 1'b0;
    endtask
    task automatic expect_out(input string nm, input logic [7:0] d, input logic [2:0] r, input logic e);
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({nm, "_data"}, 32'(bus.out_data), 32'(d));
        chk({nm, "_rem"}, 32'(bus.out_rem), 32'(r));
        chk({nm, "_err"}, 32'(bus.crc_err), 32'(e));
    endtask
    task automatic handshake(input int delay, input logic e);
        for (int k = 0; k < delay; k++) begin
            bus.out_ready = 1'b0;
            tick();
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_bit_ready", 32'(bus.bit_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        fc = fc < 255 ? fc + 1 : 255;
        if (e) ec = ec < 255 ? ec + 1 : 255;
        tick();
        bus.out_ready = 1'b0;
        chk("done_valid", 32'(bus.out_valid), 32'd0);
        chk("done_bit_ready", 32'(bus.bit_ready), 32'd1);
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(fc));
        chk("err_cnt", 32'(bus.err_cnt), 32'(ec));
    endtask
    task automatic frame(input string nm, input logic [10:0] cw, input logic [3:0] dv, input bit gaps, input int delay);
        logic [2:0] r;
        logic e;
        bus.divisor = dv;
        send(cw, 11, gaps, dv);
        r = model_rem(cw, dv);
        e = (r != 3'd0) || !dv[3];
        expect_out(nm, cw[10:3], r, e);
        handshake(delay, e);
    endtask
    initial begin
        logic [10:0] cw;
        logic [3:0] dv;
        tbl[0] = '{4'b1011, 11'b00000001011, 8'h01, 3'b000, 1'b0};
        tbl[1] = '{4'b1011, 11'b10000000011, 8'h80, 3'b000, 1'b0};
        tbl[2] = '{4'b1011, 11'b00000001010, 8'h01, 3'b001, 1'b1};
        tbl[3] = '{4'b0011, 11'b00000000000, 8'h00, 3'b000, 1'b1};
        tbl[4] = '{4'b1011, 11'b11111111111, 8'hFF, 3'b100, 1'b1};
        tbl[5] = '{4'b1101, 11'b00000001101, 8'h01, 3'b000, 1'b0};
        bus.divisor = 4'b1011;
        bus.bit_in = 1'b0;
        bus.bit_valid = 1'b0;
        bus.frame_abort = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_bit_ready", 32'(bus.bit_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_rem", 32'(bus.out_rem), 32'd0);
        chk("rst_crc_err", 32'(bus.crc_err), 32'd0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.divisor = tbl[i].dv;
            send(tbl[i].cw, 11, 1'b0, tbl[i].dv);
            expect_out("tbl", tbl[i].d, tbl[i].r, tbl[i].e);
            handshake(i % 3, tbl[i].e);
        end
        bus.divisor = 4'b1011;
        send(11'b10000000011, 11, 1'b0, 4'b1011);
        for (int k = 0; k < 5; k++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in = 1'b1;
            tick();
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_bit_ready", 32'(bus.bit_ready), 32'd0);
            chk("stall_data", 32'(bus.out_data), 32'h80);
            chk("stall_rem", 32'(bus.out_rem), 32'd0);
            chk("stall_err", 32'(bus.crc_err), 32'd0);
        end
        bus.bit_valid = 1'b0;
        handshake(0, 1'b0);
        frame("post_stall", 11'b00000001011, 4'b1011, 1'b0, 0);
        bus.divisor = 4'b1011;
        send(11'b11011011011, 10, 1'b0, 4'b1011);
        bus.frame_abort = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b1;
        tick();
        bus.frame_abort = 1'b0;
        bus.bit_valid = 1'b0;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        frame("abort_recv", 11'b00000001011, 4'b1011, 1'b0, 0);
        bus.frame_abort = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b1;
        tick();
        bus.frame_abort = 1'b0;
        bus.bit_valid = 1'b0;
        frame("abort_idle", 11'b10000000011, 4'b1011, 1'b0, 0);
        bus.divisor = 4'b1011;
        send(11'b00000001010, 11, 1'b0, 4'b1011);
        bus.frame_abort = 1'b1;
        tick();
        bus.frame_abort = 1'b0;
        expect_out("abort_hold", 8'h01, 3'b001, 1'b1);
        handshake(1, 1'b1);
        bus.divisor = 4'b1011;
        send(11'b00000001011, 11, 1'b0, 4'b0011);
        expect_out("div_latch", 8'h01, 3'b000, 1'b0);
        handshake(1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            dv = 4'($urandom);
            cw = 11'($urandom);
            if ($urandom_range(0, 1) == 1) cw[2:0] = model_rem({cw[10:3], 3'b000}, dv);
            frame("rand", cw, dv, 1'b1, $urandom_range(0, 3));
        end
        for (int k = 0; k < 260; k++)
            frame("sat", 11'b00000001011, 4'b1011, 1'b0, 0);
        chk("sat_frame_cnt", 32'(bus.frame_cnt), 32'hFF);
        for (int k = 0; k < 260; k++)
            frame("sat_err", 11'b00000001010, 4'b1011, 1'b0, 0);
        chk("sat_err_cnt", 32'(bus.err_cnt), 32'hFF);
        bus.divisor = 4'b1011;
        send(11'b11111111111, 6, 1'b0, 4'b1011);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fc = 0;
        ec = 0;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_bit_ready", 32'(bus.bit_ready), 32'd1);
        chk("mid_rst_data", 32'(bus.out_data), 32'd0);
        chk("mid_rst_rem", 32'(bus.out_rem), 32'd0);
        chk("mid_rst_err", 32'(bus.crc_err), 32'd0);
        chk("mid_rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("mid_rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        frame("post_rst", 11'b10000000011, 4'b1011, 1'b0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/crc_rx_check.md
Name: crc_rx_check

Overview:
- Bit-serial CRC receive checker that sits directly downstream of the CRC codeword generator.
- Accepts one 11-bit codeword (8 data bits followed by 3 check bits) one bit per handshake, with codeword index 0 first.
- Divides the codeword by the 4-bit generator polynomial using a 3-bit LFSR.
- Presents the recovered data byte, the remainder and an error flag on a valid/ready output, and keeps saturating frame and error counters.

Parameters:
- DATA_W, 8, data bits per codeword.
- CRC_W, 3, check bits per codeword; the generator is CRC_W+1 bits wide.
- CNT_W, 8, width of the frame and error counters.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- divisor  input  [0:3]  generator polynomial; bit 0 is the x^3 coefficient. Sampled on the first bit of each frame.
- bit_in  input  1  serial codeword bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block can accept a bit this cycle.
- frame_abort  input  1  discards the partial frame.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  [0:7]  first 8 received bits; bit 0 is received first.
- out_rem  output  [0:2]  remainder of codeword mod divisor.
- crc_err  output  1  out_rem != 0, or the latched divisor[0] == 0.
- frame_cnt  output  CNT_W  frames delivered; saturates at all-ones.
- err_cnt  output  CNT_W  delivered frames with crc_err=1; saturates.

Behaviour:
- **Reset** (rst high at a clk edge): state=IDLE, bit count=0, remainder=0, out_valid=0, out_data=0, out_rem=0, crc_err=0, frame_cnt=0, err_cnt=0. bit_ready is 1 in the cycle after reset. Reset mid-frame or during HOLD drops the frame without counting it.
- **Bit accept**: a bit is accepted when bit_valid && bit_ready at the clk edge. bit_ready = (state != HOLD) and is combinational from state only.
- **LFSR step** per accepted bit b, with r = remainder[0:2] and g = latched divisor:
  - fb = r[0]
  - r_next = {r[1], r[2], b} XOR (fb ? g[1:3] : 3'b000)
  - The first bit of a frame uses r = 000 and the live divisor value, which is latched at the same time.
- **Data capture**: accepted bits 0..7 shift into the data register in index order. Bits 8..10 feed only the LFSR.
- **State machine**:
  - IDLE → RECV on the first accepted bit; count becomes 1.
  - RECV: count increments per accepted bit. When the 11th bit (count==10) is accepted → HOLD.
  - On entry to HOLD, all of the following register on the same edge as the 11th bit:
    - out_data, out_rem = final r_next.
    - crc_err = (r_next != 0) | ~g[0].
    - out_valid=1.
  - Latency: out_valid is high the cycle after the last bit is accepted.
  - HOLD: out_valid stays high and out_data, out_rem and crc_err are stable until out_valid && out_ready. At that edge: out_valid=0; frame_cnt+1 (saturating); err_cnt+1 if crc_err (saturating); count and remainder clear; → IDLE.
  - Bits presented during HOLD are not accepted, because bit_ready=0.
- **Abort**:
  - frame_abort in IDLE or RECV clears the count and remainder → IDLE. A bit accepted in the same cycle is discarded.
  - frame_abort in HOLD is ignored; the result stays pending.
- **Simultaneous events**: rst has priority over everything, then frame_abort, then bit accept.
- **Output values**: out_data, out_rem and crc_err retain their last delivered values after the handshake, but are don't-care while out_valid=0.
- **Throughput**: at most one frame per 12 clk cycles (11 bits plus 1 output handshake cycle).
- **Counter saturation**: frame_cnt and err_cnt hold at 8'hFF; they never wrap.

Test Plan:
1. divisor=1011, serial bits 00000001011 back-to-back → out_valid 1 cycle after the 11th bit; out_data=00000001, out_rem=000, crc_err=0; frame_cnt=1 after the handshake.
2. divisor=1011, bits 10000000011 with out_ready held low for 5 cycles → outputs stable, bit_ready=0 throughout, out_data=10000000, out_rem=000. Then raise out_ready → IDLE, bit_ready=1 next cycle.
3. divisor=1011, bits 00000001010 (last bit flipped) → out_rem=001, crc_err=1, err_cnt=1.
4. Assert frame_abort after 5 bits, then send 00000001011 → only the second frame is reported, with out_rem=000 and frame_cnt=1. Then change divisor to 0011 mid-frame → no effect on the latched generator.
5. divisor=0011 at the frame start, bits all 0 → out_rem=000, crc_err=1 (illegal generator).
6. 260 good frames → frame_cnt saturates at FF. Then assert rst during RECV → all outputs 0, frame discarded.
